// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_arbiter
// Description : Shares one main-memory port between the instruction cache
//               (requester 0) and the data cache (requester 1). Requests are
//               arbitrated round-robin and forwarded combinationally; an
//               in-order ID queue steers memory responses back to the
//               requester that issued the oldest outstanding request.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
  parameter int REQ_W  = 77,
  parameter int RESP_W = 47,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req0_val,
  output logic              req0_rdy,
  input  logic [REQ_W-1:0]  req0_msg,

  input  logic              req1_val,
  output logic              req1_rdy,
  input  logic [REQ_W-1:0]  req1_msg,

  output logic              resp0_val,
  input  logic              resp0_rdy,
  output logic [RESP_W-1:0] resp0_msg,

  output logic              resp1_val,
  input  logic              resp1_rdy,
  output logic [RESP_W-1:0] resp1_msg,

  output logic              memreq_val,
  input  logic              memreq_rdy,
  output logic [REQ_W-1:0]  memreq_msg,

  input  logic              memresp_val,
  output logic              memresp_rdy,
  input  logic [RESP_W-1:0] memresp_msg
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [PW:0]   c_CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   c_CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] c_PTR_ONE  = PW'(1);

  logic          r_prio;
  logic          r_queue [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;

  logic w_gnt0;
  logic w_gnt1;
  logic w_full;
  logic w_empty;
  logic w_head_id;
  logic w_push;
  logic w_pop;

  // Round-robin grant: a lone requester always wins, ties go to r_prio.
  always_comb begin
    w_gnt0 = req0_val & (~req1_val | ~r_prio);
    w_gnt1 = req1_val & (~req0_val |  r_prio);
  end

  // Request path: forward the winner to memory, blocked while the queue is
  // full; every handshake output is held low while reset is asserted.
  always_comb begin
    w_full     = (r_count == c_CNT_FULL);
    memreq_val = (req0_val | req1_val) & ~w_full & ~reset;
    memreq_msg = w_gnt1 ? req1_msg : req0_msg;
    req0_rdy   = w_gnt0 & memreq_rdy & ~w_full & ~reset;
    req1_rdy   = w_gnt1 & memreq_rdy & ~w_full & ~reset;
    w_push     = memreq_val & memreq_rdy;
  end

  // Response path: steer the memory response to the requester at the head
  // of the tracking queue; nothing is accepted while the queue is empty.
  always_comb begin
    w_empty     = (r_count == '0);
    w_head_id   = r_queue[r_head];
    resp0_val   = memresp_val & ~w_empty & ~w_head_id & ~reset;
    resp1_val   = memresp_val & ~w_empty &  w_head_id & ~reset;
    resp0_msg   = memresp_msg;
    resp1_msg   = memresp_msg;
    memresp_rdy = ~w_empty & (w_head_id ? resp1_rdy : resp0_rdy) & ~reset;
    w_pop       = memresp_val & memresp_rdy;
  end

  // Tracking-queue storage: record the winner ID at the tail on each push.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_queue[r_tail] <= w_gnt1;
    end
  end

  // Pointers, occupancy and priority; a simultaneous push and pop leaves the
  // count unchanged while both pointers advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio  <= 1'b0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + c_PTR_ONE;
        r_prio <= ~w_gnt1;
      end
      if (w_pop) begin
        r_head <= r_head + c_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_ONE;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_CNT_ONE;
      end
    end
  end

`ifndef SYNTHESIS
  // A memory response with nothing outstanding means memory broke ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(memresp_val && w_empty));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_mem_arbiter
// Description : Directed self-checking bench for cache_mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

  localparam int REQ_W  = 77;
  localparam int RESP_W = 47;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_val, req0_rdy;
  logic [REQ_W-1:0]  req0_msg;
  logic              req1_val, req1_rdy;
  logic [REQ_W-1:0]  req1_msg;
  logic              resp0_val, resp0_rdy;
  logic [RESP_W-1:0] resp0_msg;
  logic              resp1_val, resp1_rdy;
  logic [RESP_W-1:0] resp1_msg;
  logic              memreq_val, memreq_rdy;
  logic [REQ_W-1:0]  memreq_msg;
  logic              memresp_val, memresp_rdy;
  logic [RESP_W-1:0] memresp_msg;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.REQ_W(REQ_W), .RESP_W(RESP_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_val   (req0_val),
    .req0_rdy   (req0_rdy),
    .req0_msg   (req0_msg),
    .req1_val   (req1_val),
    .req1_rdy   (req1_rdy),
    .req1_msg   (req1_msg),
    .resp0_val  (resp0_val),
    .resp0_rdy  (resp0_rdy),
    .resp0_msg  (resp0_msg),
    .resp1_val  (resp1_val),
    .resp1_rdy  (resp1_rdy),
    .resp1_msg  (resp1_msg),
    .memreq_val (memreq_val),
    .memreq_rdy (memreq_rdy),
    .memreq_msg (memreq_msg),
    .memresp_val(memresp_val),
    .memresp_rdy(memresp_rdy),
    .memresp_msg(memresp_msg)
  );

  task automatic idle_inputs();
    req0_val    = 1'b0;
    req1_val    = 1'b0;
    req0_msg    = '0;
    req1_msg    = '0;
    resp0_rdy   = 1'b1;
    resp1_rdy   = 1'b1;
    memreq_rdy  = 1'b1;
    memresp_val = 1'b0;
    memresp_msg = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset     = 1'b1;
    req0_val  = 1'b1;
    req1_val  = 1'b1;
    next_cycle();
    #1;
    total_cnt++; if (memreq_val !== 1'b0) $display("FAIL rst_memreq_val got %b exp 0", memreq_val); else pass_cnt++;
    total_cnt++; if (req0_rdy !== 1'b0) $display("FAIL rst_req0_rdy got %b exp 0", req0_rdy); else pass_cnt++;
    total_cnt++; if (req1_rdy !== 1'b0) $display("FAIL rst_req1_rdy got %b exp 0", req1_rdy); else pass_cnt++;
    next_cycle();
    idle_inputs();
    reset = 1'b0;
    #1;
    total_cnt++; if (memreq_val !== 1'b0) $display("FAIL post_rst_memreq_val got %b exp 0", memreq_val); else pass_cnt++;
    total_cnt++; if (req0_rdy !== 1'b0 || req1_rdy !== 1'b0) $display("FAIL post_rst_req_rdy got %b%b exp 00", req0_rdy, req1_rdy); else pass_cnt++;
    total_cnt++; if (resp0_val !== 1'b0 || resp1_val !== 1'b0) $display("FAIL post_rst_resp_val got %b%b exp 00", resp0_val, resp1_val); else pass_cnt++;
    total_cnt++; if (memresp_rdy !== 1'b0) $display("FAIL post_rst_memresp_rdy got %b exp 0", memresp_rdy); else pass_cnt++;
    next_cycle();
  endtask

  // req0 issues four reads; memory answers two cycles later.
  task automatic test_back_to_back();
    logic [REQ_W-1:0]  exp_req;
    logic [RESP_W-1:0] exp_resp;
    pulse_reset();
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      exp_req  = REQ_W'(32'h1000 + 4*c);
      exp_resp = RESP_W'(32'hA0 + c - 2);
      if (c < 4) begin
        req0_val = 1'b1;
        req0_msg = exp_req;
      end
      if (c >= 2) begin
        memresp_val = 1'b1;
        memresp_msg = exp_resp;
      end
      #1;
      if (c < 4) begin
        total_cnt++; if (memreq_val !== 1'b1 || memreq_msg !== exp_req) $display("FAIL b2b_memreq c=%0d got %b/%h exp 1/%h", c, memreq_val, memreq_msg, exp_req); else pass_cnt++;
        total_cnt++; if (req0_rdy !== 1'b1) $display("FAIL b2b_req0_rdy c=%0d got %b exp 1", c, req0_rdy); else pass_cnt++;
      end
      if (c >= 2) begin
        total_cnt++; if (resp0_val !== 1'b1 || resp0_msg !== exp_resp) $display("FAIL b2b_resp0 c=%0d got %b/%h exp 1/%h", c, resp0_val, resp0_msg, exp_resp); else pass_cnt++;
      end
      total_cnt++; if (resp1_val !== 1'b0) $display("FAIL b2b_resp1_val c=%0d got %b exp 0", c, resp1_val); else pass_cnt++;
      next_cycle();
    end
    idle_inputs();
    #1;
    total_cnt++; if (memresp_rdy !== 1'b0) $display("FAIL b2b_drained_memresp_rdy got %b exp 0", memresp_rdy); else pass_cnt++;
  endtask

  // Both requesters contend for six cycles; grants alternate from 0.
  task automatic test_contention();
    logic              exp_win;
    logic              exp_id;
    logic [REQ_W-1:0]  exp_req;
    pulse_reset();
    for (int c = 0; c < 8; c++) begin
      idle_inputs();
      exp_win = c[0];
      exp_id  = (c >= 2) ? c[0] : 1'b0;
      if (c < 6) begin
        req0_val = 1'b1;
        req1_val = 1'b1;
        req0_msg = REQ_W'(32'h100 + c);
        req1_msg = REQ_W'(32'h200 + c);
      end
      if (c >= 2) begin
        memresp_val = 1'b1;
        memresp_msg = RESP_W'(32'h300 + c);
      end
      #1;
      if (c < 6) begin
        exp_req = exp_win ? REQ_W'(32'h200 + c) : REQ_W'(32'h100 + c);
        total_cnt++; if (memreq_msg !== exp_req) $display("FAIL cont_memreq_msg c=%0d got %h exp %h", c, memreq_msg, exp_req); else pass_cnt++;
        total_cnt++; if (req0_rdy !== ~exp_win || req1_rdy !== exp_win) $display("FAIL cont_rdy c=%0d got %b%b exp %b%b", c, req0_rdy, req1_rdy, ~exp_win, exp_win); else pass_cnt++;
      end
      if (c >= 2) begin
        total_cnt++; if (resp0_val !== ~exp_id || resp1_val !== exp_id) $display("FAIL cont_resp_val c=%0d got %b%b exp %b%b", c, resp0_val, resp1_val, ~exp_id, exp_id); else pass_cnt++;
      end
      next_cycle();
    end
  endtask

  // Fill the queue with no responses; one pop re-enables requests next cycle.
  task automatic test_full();
    pulse_reset();
    for (int c = 0; c < DEPTH; c++) begin
      idle_inputs();
      req0_val = 1'b1;
      req0_msg = REQ_W'(32'h2000 + c);
      #1;
      total_cnt++; if (memreq_val !== 1'b1) $display("FAIL full_fill_memreq_val c=%0d got %b exp 1", c, memreq_val); else pass_cnt++;
      next_cycle();
    end
    idle_inputs();
    req0_val = 1'b1;
    req1_val = 1'b1;
    #1;
    total_cnt++; if (memreq_val !== 1'b0) $display("FAIL full_memreq_val got %b exp 0", memreq_val); else pass_cnt++;
    total_cnt++; if (req0_rdy !== 1'b0 || req1_rdy !== 1'b0) $display("FAIL full_req_rdy got %b%b exp 00", req0_rdy, req1_rdy); else pass_cnt++;
    next_cycle();
    memresp_val = 1'b1;
    #1;
    total_cnt++; if (memresp_rdy !== 1'b1) $display("FAIL full_pop_memresp_rdy got %b exp 1", memresp_rdy); else pass_cnt++;
    total_cnt++; if (memreq_val !== 1'b0) $display("FAIL full_pop_same_cycle_memreq_val got %b exp 0", memreq_val); else pass_cnt++;
    next_cycle();
    memresp_val = 1'b0;
    #1;
    total_cnt++; if (memreq_val !== 1'b1) $display("FAIL full_reenable_memreq_val got %b exp 1", memreq_val); else pass_cnt++;
    total_cnt++; if (req1_rdy !== 1'b1 || req0_rdy !== 1'b0) $display("FAIL full_reenable_rdy got %b%b exp 01", req0_rdy, req1_rdy); else pass_cnt++;
    req0_val = 1'b0;
    req1_val = 1'b0;
    next_cycle();
  endtask

  // Head entry belongs to requester 1, which stalls for three cycles.
  task automatic test_backpressure();
    pulse_reset();
    idle_inputs();
    req1_val = 1'b1;
    next_cycle();
    idle_inputs();
    req0_val = 1'b1;
    next_cycle();
    idle_inputs();
    memresp_val = 1'b1;
    resp1_rdy   = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total_cnt++; if (memresp_rdy !== 1'b0) $display("FAIL bp_memresp_rdy c=%0d got %b exp 0", c, memresp_rdy); else pass_cnt++;
      total_cnt++; if (resp1_val !== 1'b1 || resp0_val !== 1'b0) $display("FAIL bp_resp_val c=%0d got %b%b exp 01", c, resp0_val, resp1_val); else pass_cnt++;
      next_cycle();
    end
    resp1_rdy = 1'b1;
    #1;
    total_cnt++; if (memresp_rdy !== 1'b1 || resp1_val !== 1'b1) $display("FAIL bp_release got rdy=%b v1=%b exp 1/1", memresp_rdy, resp1_val); else pass_cnt++;
    next_cycle();
    resp1_rdy = 1'b0;
    #1;
    total_cnt++; if (resp0_val !== 1'b1 || resp1_val !== 1'b0 || memresp_rdy !== 1'b1) $display("FAIL bp_head_advance got v=%b%b rdy=%b exp 10/1", resp0_val, resp1_val, memresp_rdy); else pass_cnt++;
    next_cycle();
  endtask

  // Queue holds {1,0}; a push of 1 and a pop in the same cycle.
  task automatic test_push_pop();
    pulse_reset();
    idle_inputs();
    req1_val = 1'b1;
    next_cycle();
    idle_inputs();
    req0_val = 1'b1;
    next_cycle();
    idle_inputs();
    req1_val    = 1'b1;
    memresp_val = 1'b1;
    #1;
    total_cnt++; if (req1_rdy !== 1'b1 || resp1_val !== 1'b1 || memresp_rdy !== 1'b1) $display("FAIL pp_both_fire got r1=%b v1=%b mr=%b exp 1/1/1", req1_rdy, resp1_val, memresp_rdy); else pass_cnt++;
    next_cycle();
    idle_inputs();
    memresp_val = 1'b1;
    #1;
    total_cnt++; if (resp0_val !== 1'b1 || resp1_val !== 1'b0) $display("FAIL pp_second got %b%b exp 10", resp0_val, resp1_val); else pass_cnt++;
    next_cycle();
    #1;
    total_cnt++; if (resp1_val !== 1'b1 || resp0_val !== 1'b0) $display("FAIL pp_third got %b%b exp 01", resp0_val, resp1_val); else pass_cnt++;
    next_cycle();
    memresp_val = 1'b0;
    #1;
    total_cnt++; if (memresp_rdy !== 1'b0) $display("FAIL pp_empty_memresp_rdy got %b exp 0", memresp_rdy); else pass_cnt++;
  endtask

  // Three requests outstanding, then a one-cycle reset discards them.
  task automatic test_reset_mid();
    pulse_reset();
    for (int c = 0; c < 3; c++) begin
      idle_inputs();
      req0_val = 1'b1;
      next_cycle();
    end
    idle_inputs();
    reset    = 1'b1;
    req0_val = 1'b1;
    #1;
    total_cnt++; if (memreq_val !== 1'b0 || req0_rdy !== 1'b0) $display("FAIL mid_rst_outputs got %b%b exp 00", memreq_val, req0_rdy); else pass_cnt++;
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    #1;
    total_cnt++; if (memresp_rdy !== 1'b0 || resp0_val !== 1'b0) $display("FAIL mid_rst_empty got rdy=%b v0=%b exp 0/0", memresp_rdy, resp0_val); else pass_cnt++;
    req0_val = 1'b1;
    req1_val = 1'b1;
    req0_msg = REQ_W'(32'h5000);
    req1_msg = REQ_W'(32'h6000);
    #1;
    total_cnt++; if (memreq_msg !== REQ_W'(32'h5000) || req0_rdy !== 1'b1 || req1_rdy !== 1'b0) $display("FAIL mid_rst_prio got msg=%h rdy=%b%b exp 5000/10", memreq_msg, req0_rdy, req1_rdy); else pass_cnt++;
    req0_val = 1'b0;
    req1_val = 1'b0;
    next_cycle();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_back_to_back();
    test_contention();
    test_full();
    test_backpressure();
    test_push_pop();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
